// File: rtl/spi_mem_ctrl_if.sv
// Host request/response and serial-memory pins of spi_mem_ctrl.
// master = controller view, slave = host/memory environment view.
interface spi_mem_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       cs;
  logic       miso;
  logic       mosi;
  logic       ready;
  logic       op_done;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, mosi, ready, op_done,
    output req_ready, resp_valid, resp_rdata, resp_err, cs, miso
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, mosi, ready, op_done,
    input  req_ready, resp_valid, resp_rdata, resp_err, cs, miso
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// Serial memory initiator: one request at a time, frames op/addr/(data) LSB first on cs/miso.
// Optional wait watchdog enabled by SPI_MEM_CTRL_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module spi_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  spi_mem_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SEL, OP, SHIFT, WAIT_RDY, RECV, WAIT_DONE
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_mem_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        miso_q, miso_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        done_ok, done_err;
  logic [15:0] frame;

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    rdata_d      = rdata_q;
    cs_d         = cs_q;
    miso_d       = miso_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    done_ok      = 1'b0;
    done_err     = 1'b0;
    frame        = wr_q ? {wdata_q, addr_q} : {8'h00, addr_q};
`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = 8'h00;
          cs_d    = 1'b0;
          miso_d  = bus.req_wr;
          state_d = SEL;
        end
      end
      SEL: state_d = OP;
      OP: begin
        miso_d    = frame[0];
        shreg_d   = {1'b0, frame[15:1]};
        bit_cnt_d = 5'd1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        // cs rises on the edge right after the last bit so the memory sees the frame end.
        if (bit_cnt_q == (wr_q ? 5'd16 : 5'd8)) begin
          cs_d      = 1'b1;
          miso_d    = 1'b0;
          bit_cnt_d = 5'd0;
          state_d   = wr_q ? WAIT_DONE : WAIT_RDY;
        end else begin
          miso_d    = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[15:1]};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      WAIT_RDY: begin
        if (bus.op_done) begin
          done_err = 1'b1;
        end else if (bus.ready) begin
          rdata_d   = {bus.mosi, rdata_q[7:1]};
          bit_cnt_d = 5'd1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (bus.op_done) begin
          done_err = 1'b1;
        end else begin
          rdata_d = {bus.mosi, rdata_q[7:1]};
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            state_d   = WAIT_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.op_done) done_ok = 1'b1;
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    if ((state_q == WAIT_RDY || state_q == RECV || state_q == WAIT_DONE) && !done_ok && !done_err) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) done_err = 1'b1;
      else tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (state_d != state_q && (state_d == WAIT_RDY || state_d == WAIT_DONE)) tmo_cnt_d = '0;
`endif

    if (done_ok || done_err) begin
      resp_valid_d = 1'b1;
      resp_err_d   = done_err;
      resp_rdata_d = (done_err || wr_q) ? 8'h00 : rdata_q;
      cs_d         = 1'b1;
      miso_d       = 1'b0;
      bit_cnt_d    = 5'd0;
      state_d      = IDLE;
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      shreg_q      <= 16'h0000;
      bit_cnt_q    <= 5'd0;
      rdata_q      <= 8'h00;
      cs_q         <= 1'b1;
      miso_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'h00;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      miso_q       <= miso_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.cs         = cs_q;
  assign bus.miso       = miso_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural serial memory.
module tb_spi_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus();
  spi_mem_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mem [256];
  int mode   = 0;   // 0 compliant, 1 silent on reads, 2 op_done after 4 read bits
  int frames = 0;
  logic [17:0] last_bits;
  int last_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: samples pins on negedges, drives responses on negedges.
  initial begin
    bus.mosi = 1'b0; bus.ready = 1'b0; bus.op_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.cs === 1'b0) begin
        logic [17:0] b;
        int n;
        logic [7:0] a;
        b = '0; n = 0;
        while (bus.cs === 1'b0 && n < 18) begin
          b[n] = bus.miso; n++;
          @(negedge clk);
        end
        if (bus.cs === 1'b1 && n == 18 && b[1:0] == 2'b11) begin
          frames++; last_bits = b; last_n = n;
          mem[b[9:2]] = b[17:10];
          @(negedge clk);
          bus.op_done = 1'b1;
          @(negedge clk);
          bus.op_done = 1'b0;
        end else if (bus.cs === 1'b1 && n == 10 && b[1:0] == 2'b00) begin
          frames++; last_bits = b; last_n = n;
          a = b[9:2];
          if (mode != 1) begin
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < ((mode == 2) ? 4 : 8); i++) begin
              bus.ready = 1'b1; bus.mosi = mem[a][i];
              @(negedge clk);
            end
            bus.ready = 1'b0; bus.mosi = 1'b0; bus.op_done = 1'b1;
            @(negedge clk);
            bus.op_done = 1'b0;
          end
        end
      end
    end
  end

  // Issue one request from a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit keep, input logic [7:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit exp_b2b);
    int waits, lat, rdy_bad;
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    waits = 0;
    while (bus.req_ready !== 1'b1 && waits < 100) begin
      @(negedge clk); waits++;
    end
    chk({tag, "_accept"}, bus.req_ready, 1);
    if (exp_b2b) chk({tag, "_b2b_wait"}, waits, 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
    chk({tag, "_cs_low"}, bus.cs, 0);
    rdy_bad = (bus.req_ready !== 1'b0) ? 1 : 0;
    for (lat = 1; lat <= 200; lat++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) break;
      if (bus.req_ready !== 1'b0) rdy_bad++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, "_err"}, bus.resp_err, exp_err);
    chk({tag, "_rdy_low"}, rdy_bad, 0);
  endtask

  initial begin
    int f, seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, seen;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    #12;
    chk("rst_cs", bus.cs, 1);
    chk("rst_miso", bus.miso, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rel_ready_lo", bus.req_ready, 0);
    @(negedge clk);
    chk("rel_ready_hi", bus.req_ready, 1);

    // 1: write 0x05 <- 0xA3
    do_req("wr1", 1'b1, 8'h05, 8'hA3, 1'b0, 8'h00, 1'b0, 20, 1'b0);
    chk("wr1_frame", last_bits, 18'h28C17);
    chk("wr1_len", last_n, 18);
    @(negedge clk);
    chk("wr1_pulse", bus.resp_valid, 0);

    // 2: read 0x05
    do_req("rd1", 1'b0, 8'h05, 8'h00, 1'b0, 8'hA3, 1'b0, 21, 1'b0);
    chk("rd1_frame", last_bits, 18'h00014);
    chk("rd1_len", last_n, 10);

    // 3: req_valid held high across write then read
    @(negedge clk);
    f = frames;
    do_req("b2b_wr", 1'b1, 8'h1F, 8'hFF, 1'b1, 8'h00, 1'b0, 20, 1'b0);
    do_req("b2b_rd", 1'b0, 8'h1F, 8'h00, 1'b1, 8'hFF, 1'b0, 21, 1'b1);
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_frames", frames - f, 2);

    // 4: async reset during write bit 5 (held after C7)
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h02; bus.req_wdata = 8'h55;
    while (bus.req_ready !== 1'b1) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_cs", bus.cs, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs", bus.cs, 1);
    chk("arst_miso", bus.miso, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen++;
    end
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen++;
    end
    chk("arst_no_resp", seen, 0);
    do_req("wr2", 1'b1, 8'h02, 8'h3C, 1'b0, 8'h00, 1'b0, 20, 1'b0);
    do_req("rd2", 1'b0, 8'h02, 8'h00, 1'b0, 8'h3C, 1'b0, 21, 1'b0);

`ifdef SPI_MEM_CTRL_TIMEOUT_EN
    // 5: silent memory on a read trips the watchdog 64 cycles after WAIT_RDY entry (C10)
    @(negedge clk);
    mode = 1;
    do_req("tmo", 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1, 74, 1'b0);
    mode = 0;
    do_req("tmo_next", 1'b0, 8'h05, 8'h00, 1'b0, 8'hA3, 1'b0, 21, 1'b0);
`endif

    // 6: op_done after only 4 read bits
    @(negedge clk);
    mode = 2;
    do_req("early", 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b1, 17, 1'b0);
    mode = 0;
    do_req("early_next", 1'b0, 8'h05, 8'h00, 1'b0, 8'hA3, 1'b0, 21, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
